fpu_scoreboard: RTL
===================

# fpu_scoreboard

Parametrised FPU hazard scoreboard for the decode/issue stage. It tracks in-flight writes to the FPU register file and to FCSR, counting down a known latency for each producer and holding unknown-latency producers (div/sqrt) until their writeback. Issue logic uses its per-read-port busy flags to stall consumers until the operand can come from the bypass network. The block sits beside the FPU operand forwarding network, which supplies the data; this block decides only whether issue must wait.

## Interface
Parameters:
- ISSUE_NUM, 2, issue slots and writeback ports.
- RD_PORTS, 4, operand read ports (fs1/fs2 per slot).
- NREG, 32, FPU registers; address width REG_W = $clog2(NREG).
- LAT_W, 4, latency field width; value 2^LAT_W-1 (LAT_INF) means unknown latency.
- TAG_W, 4, producer tag width; must exceed log2(max in-flight FPU writers).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  drop all tracked producers.
- issue_valid_i  in  ISSUE_NUM  slot issues this cycle.
- issue_we_i  in  ISSUE_NUM  slot writes an FPU register.
- issue_fcsr_we_i  in  ISSUE_NUM  slot writes FCSR.
- issue_waddr_i  in  ISSUE_NUM x REG_W  destination register.
- issue_lat_i  in  ISSUE_NUM x LAT_W  cycles until the result is on the bypass network.
- issue_tag_o  out  ISSUE_NUM x TAG_W  tag assigned to each writer slot (combinational).
- wb_valid_i  in  ISSUE_NUM  writeback port active.
- wb_we_i  in  ISSUE_NUM  writeback targets a register.
- wb_fcsr_we_i  in  ISSUE_NUM  writeback targets FCSR.
- wb_waddr_i  in  ISSUE_NUM x REG_W  writeback register.
- wb_tag_i  in  ISSUE_NUM x TAG_W  producer tag.
- rd_addr_i  in  RD_PORTS x REG_W  operand addresses.
- rd_busy_o  out  RD_PORTS  operand not yet available; stall.
- fcsr_busy_o  out  1  FCSR not yet available.
- idle_o  out  1  no pending producer.

## Operation
- Per register r, and for FCSR: pending bit, tag[TAG_W], cnt[LAT_W].
- busy(r) = pending(r) && cnt(r) != 0. rd_busy_o[p] = busy(rd_addr_i[p]); fcsr_busy_o = busy(FCSR). Both use registered state only. No same-cycle issue or writeback bypass.
- Hazards between slots of one bundle are resolved by the issue logic, not by this block.
- Tag counter `next_tag`:
  - A slot is a writer if issue_valid_i && (we || fcsr_we).
  - Writer k in slot order (k = 0, 1, ...) gets next_tag + k. Non-writer slots output tag don't-care.
  - next_tag advances by the writer count, mod 2^TAG_W.
- Issue with lat L:
  - L = 0: the entry is not set pending.
  - Otherwise: pending = 1, tag = assigned tag, cnt = L.
  - Same target in two slots of one cycle: the higher slot wins.
- Countdown: each cycle, cnt decrements if it is nonzero and not LAT_INF. cnt = 0 with pending = 1 means ready on the bypass network, awaiting writeback.
- Writeback: clears pending and cnt only if the entry tag equals wb_tag_i. A stale tag from WAW is ignored.
- Simultaneous events on the same entry: issue beats writeback; flush beats both.
- flush_i: clears all pending and cnt; next_tag is unchanged. Issue in a flush cycle is discarded. The environment asserts flush only when every surviving FPU op has already written back.
- idle_o = no pending bit set (registered).

## Timing
- Reset (async, rst_n = 0):
  - All pending, cnt, tag and next_tag are 0.
  - rd_busy_o = 0, fcsr_busy_o = 0, idle_o = 1.
  - issue_tag_o = 0.
- Issue at cycle t with 1 ≤ L < LAT_INF: busy from t+1 through t+L, clear at t+L+1.
- L = LAT_INF: busy from t+1 until the cycle after the matching writeback.
- Writeback at cycle t clears busy and pending from t+1.
- issue_tag_o is valid in the same cycle as issue_valid_i.
- Tag wrap: 2^TAG_W-1 is followed by 0 with no gap.

## Test plan
- Reset: rst_n = 0 mid-operation with f3 pending and L = LAT_INF → all outputs go to reset values immediately, asynchronously; idle_o = 1.
- Fixed latency: issue slot0 f5, L = 3, at t = 0; rd_addr = 5 → rd_busy_o = 1 at t = 1..3, 0 at t = 4. Writeback tag 0 at t = 6 → idle_o = 1 at t = 7.
- Unknown latency: issue div f7, L = 15, tag 2 → busy held 20 cycles. Writeback f7 tag 2 at t = 20 → busy = 0 at t = 21.
- WAW and stale writeback:
  - Issue f4 L = 15 (tag 0), then f4 L = 2 (tag 1). Writeback tag 0 → f4 stays pending.
  - Writeback tag 1 → f4 clears.
  - Same cycle, slot0 and slot1 both target f4 → slot1's tag is kept.
- FCSR plus simultaneity: slot0 sets fcsr_we with L = 2 while the same-cycle writeback of an older FCSR tag arrives → fcsr_busy_o = 1 for 2 cycles; the older writeback has no effect.
- Flush and tag wrap:
  - Set next_tag = 15, issue two writers → tags 15 and 0; next_tag becomes 1.
  - Assert flush_i with an issue in the same cycle → idle_o = 1 next cycle; the issued op is not tracked.

Source files
------------

// File: rtl/fpu_scoreboard.sv
// fpu_scoreboard: tracks in-flight FPU register/FCSR writers and flags operands that must stall issue.
// Entry NREG holds FCSR; cnt == LAT_INF holds an unknown-latency producer until its tagged writeback.
module fpu_scoreboard #(
    parameter int ISSUE_NUM = 2,
    parameter int RD_PORTS  = 4,
    parameter int NREG      = 32,
    parameter int LAT_W     = 4,
    parameter int TAG_W     = 4,
    localparam int REG_W    = $clog2(NREG)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush_i,
    input  logic [ISSUE_NUM-1:0]             issue_valid_i,
    input  logic [ISSUE_NUM-1:0]             issue_we_i,
    input  logic [ISSUE_NUM-1:0]             issue_fcsr_we_i,
    input  logic [ISSUE_NUM-1:0][REG_W-1:0]  issue_waddr_i,
    input  logic [ISSUE_NUM-1:0][LAT_W-1:0]  issue_lat_i,
    output logic [ISSUE_NUM-1:0][TAG_W-1:0]  issue_tag_o,
    input  logic [ISSUE_NUM-1:0]             wb_valid_i,
    input  logic [ISSUE_NUM-1:0]             wb_we_i,
    input  logic [ISSUE_NUM-1:0]             wb_fcsr_we_i,
    input  logic [ISSUE_NUM-1:0][REG_W-1:0]  wb_waddr_i,
    input  logic [ISSUE_NUM-1:0][TAG_W-1:0]  wb_tag_i,
    input  logic [RD_PORTS-1:0][REG_W-1:0]   rd_addr_i,
    output logic [RD_PORTS-1:0]              rd_busy_o,
    output logic                             fcsr_busy_o,
    output logic                             idle_o
);
    localparam int NE = NREG + 1;
    localparam int EW = $clog2(NE);
    localparam logic [LAT_W-1:0] LAT_INF = {LAT_W{1'b1}};

    logic [NE-1:0]              pend_q, pend_d, busy;
    logic [NE-1:0][TAG_W-1:0]   tag_q, tag_d;
    logic [NE-1:0][LAT_W-1:0]   cnt_q, cnt_d;
    logic [TAG_W-1:0]           next_tag_q, next_tag_d, tag_acc;
    logic [ISSUE_NUM-1:0]       wr;

    assign wr = issue_valid_i & (issue_we_i | issue_fcsr_we_i);

    always_comb begin
        pend_d  = pend_q;
        tag_d   = tag_q;
        tag_acc = next_tag_q;
        for (int e = 0; e < NE; e++) begin
            cnt_d[e] = (cnt_q[e] != '0 && cnt_q[e] != LAT_INF) ? cnt_q[e] - LAT_W'(1) : cnt_q[e];
        end
        for (int j = 0; j < ISSUE_NUM; j++) begin
            if (wb_valid_i[j] && wb_we_i[j] && tag_q[EW'(wb_waddr_i[j])] == wb_tag_i[j]) begin
                pend_d[EW'(wb_waddr_i[j])] = 1'b0;
                cnt_d[EW'(wb_waddr_i[j])]  = '0;
            end
            if (wb_valid_i[j] && wb_fcsr_we_i[j] && tag_q[NREG] == wb_tag_i[j]) begin
                pend_d[NREG] = 1'b0;
                cnt_d[NREG]  = '0;
            end
        end
        // Slot order gives both tag numbering and "higher slot wins" on a shared target.
        for (int k = 0; k < ISSUE_NUM; k++) begin
            issue_tag_o[k] = tag_acc;
            if (wr[k] && issue_lat_i[k] != '0) begin
                if (issue_we_i[k]) begin
                    pend_d[EW'(issue_waddr_i[k])] = 1'b1;
                    tag_d[EW'(issue_waddr_i[k])]  = tag_acc;
                    cnt_d[EW'(issue_waddr_i[k])]  = issue_lat_i[k];
                end
                if (issue_fcsr_we_i[k]) begin
                    pend_d[NREG] = 1'b1;
                    tag_d[NREG]  = tag_acc;
                    cnt_d[NREG]  = issue_lat_i[k];
                end
            end
            tag_acc = tag_acc + TAG_W'(wr[k]);
        end
        next_tag_d = flush_i ? next_tag_q : tag_acc;
        if (flush_i) begin
            pend_d = '0;
            cnt_d  = '0;
            tag_d  = tag_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= '0;
            tag_q      <= '0;
            cnt_q      <= '0;
            next_tag_q <= '0;
        end else begin
            pend_q     <= pend_d;
            tag_q      <= tag_d;
            cnt_q      <= cnt_d;
            next_tag_q <= next_tag_d;
        end
    end

    always_comb begin
        for (int e = 0; e < NE; e++) busy[e] = pend_q[e] && cnt_q[e] != '0;
        for (int p = 0; p < RD_PORTS; p++) rd_busy_o[p] = busy[EW'(rd_addr_i[p])];
    end

    assign fcsr_busy_o = busy[NREG];
    assign idle_o      = ~|pend_q;
endmodule
